// File: rtl/twiddle_mult.sv
// Complex twiddle multiplier: captures 8 Q8.8 samples, selects a twiddle ROM set,
// then streams 8 saturated products x[k]*W[k] through a two-stage pipeline.
module twiddle_mult #(
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [1:0]             i_stage,
  input  logic [8*WORD_SIZE-1:0] i_x_re,
  input  logic [8*WORD_SIZE-1:0] i_x_im,
  input  logic [8*WORD_SIZE-1:0] i_w_re,
  input  logic [8*WORD_SIZE-1:0] i_w_im,
  output logic [1:0]             o_choose_twiddle,
  output logic [WORD_SIZE-1:0]   o_re,
  output logic [WORD_SIZE-1:0]   o_im,
  output logic [2:0]             o_idx,
  output logic                   o_valid,
  output logic                   o_done,
  output logic                   o_busy
);

  localparam int unsigned W    = WORD_SIZE;
  localparam int unsigned NUM  = 8;
  localparam int unsigned BW   = NUM * W;
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned SW   = PW + 1;
  localparam int unsigned FRAC = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic          cap_x_c, cap_w_c, issue_c;

  logic [BW-1:0] x_re_q, x_im_q, w_re_q, w_im_q;
  logic [1:0]    choose_q;
  logic          busy_q;

  logic signed [PW-1:0] s1_rr_q, s1_ii_q, s1_ri_q, s1_ir_q;
  logic                 s1_valid_q;
  logic [2:0]           s1_idx_q;

  logic [W-1:0]  re_q, im_q;
  logic [2:0]    idx_q;
  logic          valid_q, done_q;

  logic signed [W-1:0]  xr_c, xi_c, wr_c, wi_c;
  logic signed [SW-1:0] re_sum_c, im_sum_c, re_sh_c, im_sh_c;

  // Clamp a shifted sum into the signed W-bit range
  function automatic logic [W-1:0] sat_word(input logic signed [SW-1:0] v);
    logic [W-1:0] r;
    if ((&v[SW-1:W-1]) || (~|v[SW-1:W-1])) begin
      r = v[W-1:0];
    end else if (v[SW-1]) begin
      r = {1'b1, {(W-1){1'b0}}};
    end else begin
      r = {1'b0, {(W-1){1'b1}}};
    end
    return r;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cap_x_c = 1'b0;
    cap_w_c = 1'b0;
    issue_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          cap_x_c = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: state_d = ST_LOAD;
      ST_LOAD: begin
        cap_w_c = 1'b1;
        k_d     = 3'd0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        issue_c = 1'b1;
        k_d     = k_q + 3'd1;
        if (k_q == 3'd7) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand select for the current index
  always_comb begin
    xr_c = x_re_q[32'(k_q) * W +: W];
    xi_c = x_im_q[32'(k_q) * W +: W];
    wr_c = w_re_q[32'(k_q) * W +: W];
    wi_c = w_im_q[32'(k_q) * W +: W];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_re_q   <= '0;
      x_im_q   <= '0;
      w_re_q   <= '0;
      w_im_q   <= '0;
      choose_q <= 2'd0;
      busy_q   <= 1'b0;
    end else begin
      if (cap_x_c) begin
        x_re_q   <= i_x_re;
        x_im_q   <= i_x_im;
        choose_q <= i_stage;
      end
      if (cap_w_c) begin
        w_re_q <= i_w_re;
        w_im_q <= i_w_im;
      end
      busy_q <= (state_d != ST_IDLE);
    end
  end

  // Stage 1: four partial products
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_rr_q    <= '0;
      s1_ii_q    <= '0;
      s1_ri_q    <= '0;
      s1_ir_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= 3'd0;
    end else begin
      s1_valid_q <= issue_c;
      if (issue_c) begin
        s1_rr_q  <= PW'(xr_c) * PW'(wr_c);
        s1_ii_q  <= PW'(xi_c) * PW'(wi_c);
        s1_ri_q  <= PW'(xr_c) * PW'(wi_c);
        s1_ir_q  <= PW'(xi_c) * PW'(wr_c);
        s1_idx_q <= k_q;
      end
    end
  end

  // Stage 2: combine, floor-shift to Q8.8, saturate
  always_comb begin
    re_sum_c = SW'(s1_rr_q) - SW'(s1_ii_q);
    im_sum_c = SW'(s1_ri_q) + SW'(s1_ir_q);
    re_sh_c  = re_sum_c >>> FRAC;
    im_sh_c  = im_sum_c >>> FRAC;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      re_q    <= '0;
      im_q    <= '0;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      done_q  <= s1_valid_q && (s1_idx_q == 3'd7);
      if (s1_valid_q) begin
        re_q  <= sat_word(re_sh_c);
        im_q  <= sat_word(im_sh_c);
        idx_q <= s1_idx_q;
      end
    end
  end

  assign o_choose_twiddle = choose_q;
  assign o_re             = re_q;
  assign o_im             = im_q;
  assign o_idx            = idx_q;
  assign o_valid          = valid_q;
  assign o_done           = done_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_twiddle_mult.sv
// Directed bench for twiddle_mult with a registered twiddle ROM model and
// hand-computed Q8.8 expectations.
module tb_twiddle_mult;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [1:0]   i_stage = 2'd0;
  logic [127:0] i_x_re = '0;
  logic [127:0] i_x_im = '0;
  logic [127:0] w_re_q = '0;
  logic [127:0] w_im_q = '0;
  logic [1:0]   o_choose_twiddle;
  logic [15:0]  o_re, o_im;
  logic [2:0]   o_idx;
  logic         o_valid, o_done, o_busy;

  twiddle_mult #(.WORD_SIZE(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stage(i_stage),
    .i_x_re(i_x_re), .i_x_im(i_x_im), .i_w_re(w_re_q), .i_w_im(w_im_q),
    .o_choose_twiddle(o_choose_twiddle), .o_re(o_re), .o_im(o_im),
    .o_idx(o_idx), .o_valid(o_valid), .o_done(o_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Twiddle sets: 0/1 = exp(+j*2*pi*k/16), 2 = 1.0, 3 = j
  logic [15:0] s0_re [8] = '{16'h0100, 16'h00ED, 16'h00B5, 16'h0062,
                             16'h0000, 16'hFF9E, 16'hFF4B, 16'hFF13};
  logic [15:0] s0_im [8] = '{16'h0000, 16'h0062, 16'h00B5, 16'h00ED,
                             16'h0100, 16'h00ED, 16'h00B5, 16'h0062};

  function automatic logic [15:0] rom_re(input logic [1:0] sel, input int k);
    if (sel <= 2'd1) return s0_re[k];
    if (sel == 2'd2) return 16'h0100;
    return 16'h0000;
  endfunction

  function automatic logic [15:0] rom_im(input logic [1:0] sel, input int k);
    if (sel <= 2'd1) return s0_im[k];
    if (sel == 2'd2) return 16'h0000;
    return 16'h0100;
  endfunction

  always @(posedge i_clk) begin
    for (int k = 0; k < 8; k++) begin
      w_re_q[k*16 +: 16] <= rom_re(o_choose_twiddle, k);
      w_im_q[k*16 +: 16] <= rom_im(o_choose_twiddle, k);
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-block capture
  int          nv, done_n, done_c;
  logic        done_at_idx7;
  logic [2:0]  v_idx [32];
  logic [15:0] v_re  [32];
  logic [15:0] v_im  [32];
  int          v_c   [32];
  logic        busy_e0, busy_c11, valid_c13;
  logic [1:0]  choose_e0;
  logic [15:0] re_c13, im_c13;

  function automatic logic [127:0] rep(input logic [15:0] v);
    return {8{v}};
  endfunction

  // Start a block sampled at E0, watch ncyc cycles; optional second start sampled at E[s2]
  task automatic run_block(input logic [1:0] st, input logic [127:0] xr, input logic [127:0] xi,
                           input int s2, input logic [1:0] st2,
                           input logic [127:0] xr2, input logic [127:0] xi2, input int ncyc);
    @(negedge i_clk);
    i_stage = st; i_x_re = xr; i_x_im = xi; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    nv = 0; done_n = 0; done_c = -1; done_at_idx7 = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge i_clk);
      if (c == 0) begin busy_e0 = o_busy; choose_e0 = o_choose_twiddle; end
      if (c == 11) busy_c11 = o_busy;
      if (c == 13) begin valid_c13 = o_valid; re_c13 = o_re; im_c13 = o_im; end
      if (o_valid && nv < 32) begin
        v_idx[nv] = o_idx; v_re[nv] = o_re; v_im[nv] = o_im; v_c[nv] = c; nv++;
      end
      if (o_done) begin
        done_n++; done_c = c;
        done_at_idx7 = o_valid && (o_idx == 3'd7);
      end
      if (c == s2 - 1) begin
        i_stage = st2; i_x_re = xr2; i_x_im = xi2; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
    end
  endtask

  logic [127:0] xr, xi;
  int           cnt;

  initial begin
    #3;
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_choose", 32'(o_choose_twiddle), 32'h0);
    check("rst_re_im_idx", {o_re, 13'(o_im), o_idx}, 32'h0);
    @(negedge i_clk); i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Unit samples against set 0
    run_block(2'd0, rep(16'h0100), '0, -1, 2'd0, '0, '0, 16);
    check("t1_nvalid", 32'(nv), 32'd8);
    check("t1_first_cycle", 32'(v_c[0]), 32'd4);
    check("t1_busy_e0", 32'(busy_e0), 32'h1);
    check("t1_choose", 32'(choose_e0), 32'h0);
    for (int i = 0; i < 8; i++) check("t1_idx_seq", 32'(v_idx[i]), 32'(i));
    check("t1_idx0", {v_re[0], v_im[0]}, 32'h0100_0000);
    check("t1_idx1", {v_re[1], v_im[1]}, 32'h00ED_0062);
    check("t1_idx2", {v_re[2], v_im[2]}, 32'h00B5_00B5);
    check("t1_idx7", {v_re[7], v_im[7]}, 32'hFF13_0062);
    check("t1_done_cnt", 32'(done_n), 32'd1);
    check("t1_done_cycle", 32'(done_c), 32'd11);
    check("t1_done_idx7", 32'(done_at_idx7), 32'h1);
    check("t1_busy_end", 32'(busy_c11), 32'h0);
    check("t1_hold_valid", 32'(valid_c13), 32'h0);
    check("t1_hold_data", {re_c13, im_c13}, 32'hFF13_0062);

    // j * j = -1
    xr = '0; xi = '0; xi[15:0] = 16'h0100;
    run_block(2'd3, xr, xi, -1, 2'd0, '0, '0, 14);
    check("t2_choose", 32'(choose_e0), 32'h3);
    check("t2_idx0", {v_re[0], v_im[0]}, 32'hFF00_0000);

    // Positive saturation and floor of -181>>8
    xr = '0; xi = '0; xr[32 +: 16] = 16'h7FFF; xi[32 +: 16] = 16'h8000;
    run_block(2'd0, xr, xi, -1, 2'd0, '0, '0, 14);
    check("t3_sat", {v_re[2], v_im[2]}, 32'h7FFF_FFFF);

    xr = '0; xi = '0; xr[32 +: 16] = 16'h0001;
    run_block(2'd0, xr, xi, -1, 2'd0, '0, '0, 14);
    check("t4_trunc_pos", {v_re[2], v_im[2]}, 32'h0000_0000);

    xr = '0; xi = '0; xr[32 +: 16] = 16'hFFFF;
    run_block(2'd0, xr, xi, -1, 2'd0, '0, '0, 14);
    check("t5_trunc_neg", {v_re[2], v_im[2]}, 32'hFFFF_FFFF);

    // Start while busy is dropped; inputs changed mid-block are not re-sampled
    run_block(2'd0, rep(16'h0100), '0, 5, 2'd3, '0, rep(16'h0100), 26);
    check("t6_nvalid", 32'(nv), 32'd8);
    check("t6_idx7", {v_re[7], v_im[7]}, 32'hFF13_0062);
    check("t6_choose", 32'(o_choose_twiddle), 32'h0);

    // Back-to-back start at E12
    xr = '0; xi = '0; xi[15:0] = 16'h0100;
    run_block(2'd0, rep(16'h0100), '0, 12, 2'd1, xr, xi, 26);
    check("t7_nvalid", 32'(nv), 32'd16);
    check("t7_second_first_cycle", 32'(v_c[8]), 32'd16);
    check("t7_second_idx", 32'(v_idx[8]), 32'h0);
    check("t7_second_idx0", {v_re[8], v_im[8]}, 32'h0000_0100);
    check("t7_choose_pass1", 32'(o_choose_twiddle), 32'h1);

    // Asynchronous reset mid-block
    @(negedge i_clk);
    i_stage = 2'd2; i_x_re = rep(16'h0100); i_x_im = '0; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (7) @(posedge i_clk);
    check("t8_pre_valid", 32'(o_valid), 32'h1);
    #2 i_rst_n = 1'b0;
    #1;
    check("t8_rst_valid", 32'(o_valid), 32'h0);
    check("t8_rst_data", {o_re, o_im}, 32'h0);
    check("t8_rst_misc", {27'd0, o_idx, o_busy, o_done}, 32'h0);
    check("t8_rst_choose", 32'(o_choose_twiddle), 32'h0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge i_clk);
      if (o_valid) cnt++;
    end
    check("t8_no_valid", 32'(cnt), 32'h0);
    check("t8_choose_after", 32'(o_choose_twiddle), 32'h0);
    run_block(2'd0, rep(16'h0100), '0, -1, 2'd0, '0, '0, 14);
    check("t8_restart_nvalid", 32'(nv), 32'd8);
    check("t8_restart_first", 32'(v_c[0]), 32'd4);
    check("t8_restart_idx2", {v_re[2], v_im[2]}, 32'h00B5_00B5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/twiddle_mult.md
# twiddle_mult

Complex twiddle-multiply stage for the 16-point FFT datapath. It captures a block of 8 complex Q8.8 samples and drives the twiddle ROM's set-select input. After the ROM's one-cycle registered latency, it latches the 8 twiddle pairs and streams out 8 saturated complex products x[k]·W[k], one per cycle. It sits between the butterfly stage that produces x[k] and the twiddle ROM, and feeds the next butterfly stage.

## Interface
- WORD_SIZE, 16, width of every real/imag word; signed two's complement Q8.8 (1.0 = 0x0100)
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_stage  in  2  twiddle set to use; copied to o_choose_twiddle on accepted start
- i_x_re  in  8*WORD_SIZE  sample real parts; element k at [k*WORD_SIZE +: WORD_SIZE]
- i_x_im  in  8*WORD_SIZE  sample imag parts, same packing
- i_w_re  in  8*WORD_SIZE  ROM outputs reg0_re..reg7_re, element k = regk_re
- i_w_im  in  8*WORD_SIZE  ROM outputs reg0_im..reg7_im
- o_choose_twiddle  out  2  registered ROM set select
- o_re  out  WORD_SIZE  product real part
- o_im  out  WORD_SIZE  product imag part
- o_idx  out  3  index k of the current product
- o_valid  out  1  o_re/o_im/o_idx valid this cycle
- o_done  out  1  one-cycle pulse, coincident with o_valid for k=7
- o_busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, WAIT, LOAD, RUN, DRAIN.
- IDLE: on i_start=1, capture i_x_re/i_x_im into the local bank, set o_choose_twiddle <= i_stage, and go to WAIT.
- WAIT: one cycle so the ROM registers pick up the new select. Go to LOAD.
- LOAD: capture i_w_re/i_w_im into the local twiddle bank, clear k, and go to RUN.
- RUN: issue index k to pipeline stage 1, then increment k. Go to DRAIN after k=7 is issued.
- DRAIN: pipeline stage 2 retires k=7. Go to IDLE.
- Pipeline stage 1 registers four signed 2W-bit products: xr·wr, xi·wi, xr·wi, xi·wr.
- Pipeline stage 2 forms:
  - re = xr·wr − xi·wi and im = xr·wi + xi·wr, each in 2W+1 bits.
  - Arithmetic shift right by 8, i.e. truncation toward −∞, no rounding.
  - Saturate to [−2^(W−1), 2^(W−1)−1].
  - Register the results into o_re/o_im, and register o_idx and o_valid alongside.
- i_start while busy is ignored, with no queuing. Inputs x and w are not re-sampled outside IDLE and LOAD respectively.
- o_re, o_im and o_idx hold their last values while o_valid=0.
- i_stage values 0 and 1 select the same ROM set. This block passes the select through unchanged.

## Timing
- Reset (async, any state): state=IDLE, k=0, both banks 0, pipeline 0, o_choose_twiddle=0, o_re=0, o_im=0, o_idx=0, o_valid=0, o_done=0, o_busy=0.
- Start accepted at edge E0: o_choose_twiddle and o_busy are valid after E0.
- The ROM updates at E1 and the twiddle bank captures at E2.
- Index k enters stage 1 at E3+k. Its output appears after E4+k: o_valid is high for the 8 consecutive cycles after E4..E11, with o_idx 0..7.
- o_done is high only in the cycle after E11. Same cycle: state=IDLE, o_busy=0.
- Start-to-first-result latency: 4 cycles. Block period: 12 cycles. Back-to-back start is accepted at E12 at the earliest.
- Reset asserted mid-block aborts immediately with no further o_valid. The first start after release behaves as from power-up.

## Test plan
- Stage 0, all x = (0x0100, 0x0000) -> 8 valids starting 4 cycles after start.
  - idx0 = (0x0100, 0x0000)
  - idx2 = (0x00B5, 0x00B5)
  - idx7 = (0xFF13, 0x0062)
  - o_done coincides with idx7.
- Stage 3, x0 = (0x0000, 0x0100) -> idx0 = (0xFF00, 0x0000), i.e. j·j = −1.
- Stage 0, x2 = (0x7FFF, 0x8000) -> idx2 = (0x7FFF, 0xFFFF), exercising positive saturation and floor of −181>>8.
- Stage 0 truncation:
  - x2 = (0x0001, 0) -> (0x0000, 0x0000).
  - x2 = (0xFFFF, 0) -> (0xFFFF, 0xFFFF).
- i_start pulsed at E0 and again at E5 with different data -> the second start is ignored and exactly 8 valids are produced. A start at E12 is accepted and its first valid follows E16.
- i_rst_n pulled low after E7 -> all outputs are 0 asynchronously. No valid follows until a new start, and o_choose_twiddle = 0.
